// File: rtl/cpu_sequencer.sv
// Execution sequencer: decides which cycles the core executes an instruction,
// handling run/halt/single-step, the rate prescaler, button debounce and input capture.
module cpu_sequencer #(
  parameter int PRESCALE = 50000,
  parameter int DEBOUNCE = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [2:0] Btns,
  input  logic       Turbo,
  input  logic       Sample,
  input  logic [7:0] Din,
  input  logic       WaitIn,
  input  logic       DinAck,
  output logic       Step,
  output logic       Running,
  output logic [2:0] BtnPulse,
  output logic [7:0] DinLatched,
  output logic       DinValid,
  output logic       Overrun
);

  localparam int PW = $clog2(PRESCALE);
  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  typedef enum logic {HALT = 1'b0, RUN = 1'b1} state_t;

  state_t          state, state_next;
  logic            pend, pend_next;
  logic [PW-1:0]   pre_cnt, pre_next;
  logic            candidate, blocked, tick, step_next, toggle;

  logic [2:0]      btn_s1, btn_s2, btn_db, btn_prev, rise;
  logic [DW-1:0]   db_cnt [3];

  logic            smp_s1, smp_s2, smp_s3, capture;

  // Debounced state flips after DEBOUNCE consecutive disagreeing synchronised samples.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      btn_s1   <= '0;
      btn_s2   <= '0;
      btn_db   <= '0;
      btn_prev <= '0;
      BtnPulse <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      btn_s1   <= Btns;
      btn_s2   <= btn_s1;
      btn_prev <= btn_db;
      BtnPulse <= rise;
      for (int i = 0; i < 3; i++) begin
        if (btn_s2[i] != btn_db[i]) begin
          if (db_cnt[i] == DW'(DEBOUNCE - 1)) begin
            btn_db[i] <= ~btn_db[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign rise   = btn_db & ~btn_prev;
  assign toggle = rise[1];

  always_comb begin
    state_next = state;
    pend_next  = pend;
    pre_next   = '0;
    candidate  = 1'b0;
    blocked    = WaitIn & ~DinValid;
    tick       = (pre_cnt == PW'(PRESCALE - 1));
    case (state)
      RUN: begin
        if (Turbo) begin
          candidate = 1'b1;
        end else begin
          candidate = tick;
          pre_next  = tick ? '0 : pre_cnt + PW'(1);
        end
        if (toggle) state_next = HALT;
      end
      HALT: begin
        candidate = pend;
        if (rise[0]) pend_next = 1'b1;
        else if (pend && !blocked) pend_next = 1'b0;
        if (toggle) state_next = RUN;
      end
    endcase
    // A mode toggle always restarts stepping from a clean slate.
    if (toggle) begin
      pend_next = 1'b0;
      pre_next  = '0;
    end
    step_next = candidate & ~blocked;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= RUN;
      Running <= 1'b1;
      pend    <= 1'b0;
      pre_cnt <= '0;
      Step    <= 1'b0;
    end else begin
      state   <= state_next;
      Running <= (state_next == RUN);
      pend    <= pend_next;
      pre_cnt <= pre_next;
      Step    <= step_next;
    end
  end

  assign capture = smp_s2 & ~smp_s3;

  // A capture wins over a same-cycle acknowledge, so the new byte stays valid.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      smp_s1     <= 1'b0;
      smp_s2     <= 1'b0;
      smp_s3     <= 1'b0;
      DinLatched <= '0;
      DinValid   <= 1'b0;
      Overrun    <= 1'b0;
    end else begin
      smp_s1 <= Sample;
      smp_s2 <= smp_s1;
      smp_s3 <= smp_s2;
      if (capture) begin
        DinLatched <= Din;
        DinValid   <= 1'b1;
        if (DinValid && !DinAck) Overrun <= 1'b1;
      end else if (DinAck) begin
        DinValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed scenarios plus a random phase, checked every cycle
// against an edge-by-edge behavioural model built from input histories.
module tb_cpu_sequencer;

  localparam int P = 4;
  localparam int D = 3;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [2:0] Btns;
  logic       Turbo, Sample, WaitIn, DinAck;
  logic [7:0] Din;
  logic       Step, Running, DinValid, Overrun;
  logic [2:0] BtnPulse;
  logic [7:0] DinLatched;

  int checks = 0;
  int errors = 0;
  int step_count = 0;
  int pulse1_count = 0;

  // behavioural model state
  logic [2:0] btn_hist[$];
  logic       smp_hist[$];
  bit         m_run, m_pend, m_step, m_valid, m_over;
  bit   [2:0] m_db, m_flip_up, m_pulse;
  int         m_len[3];
  int         m_n;
  logic [7:0] m_latched;

  always #5 Clock = ~Clock;

  cpu_sequencer #(.PRESCALE(P), .DEBOUNCE(D)) dut (
    .Clock(Clock), .Reset(Reset), .Btns(Btns), .Turbo(Turbo), .Sample(Sample),
    .Din(Din), .WaitIn(WaitIn), .DinAck(DinAck), .Step(Step), .Running(Running),
    .BtnPulse(BtnPulse), .DinLatched(DinLatched), .DinValid(DinValid), .Overrun(Overrun)
  );

  task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    btn_hist.delete();
    smp_hist.delete();
    repeat (3) begin
      btn_hist.push_front(3'b000);
      smp_hist.push_front(1'b0);
    end
    m_run = 1; m_pend = 0; m_step = 0; m_valid = 0; m_over = 0;
    m_db = '0; m_flip_up = '0; m_pulse = '0; m_n = 0; m_latched = '0;
    for (int i = 0; i < 3; i++) m_len[i] = 0;
  endtask

  // One rising edge of the reference: index 2 of a history is the synchronised view.
  task automatic modelEdge();
    logic [2:0] rise, flip_now, raw2;
    logic       blocked, cand, stp, toggle, cap;
    if (Reset) begin
      modelReset();
      return;
    end
    btn_hist.push_front(Btns);
    if (btn_hist.size() > 4) void'(btn_hist.pop_back());
    smp_hist.push_front(Sample);
    if (smp_hist.size() > 4) void'(smp_hist.pop_back());

    rise    = m_flip_up;
    toggle  = rise[1];
    blocked = WaitIn && !m_valid;
    if (m_run && !Turbo) m_n++;
    else m_n = 0;
    if (!m_run) cand = m_pend;
    else if (Turbo) cand = 1'b1;
    else cand = (m_n % P == 0);
    stp = cand && !blocked;

    if (toggle) m_pend = 0;
    else if (!m_run && rise[0]) m_pend = 1;
    else if (!m_run && stp) m_pend = 0;
    if (toggle) begin
      m_run = !m_run;
      m_n   = 0;
    end

    cap = smp_hist[2] && !smp_hist[3];
    if (cap) begin
      if (m_valid && !DinAck) m_over = 1;
      m_latched = Din;
      m_valid   = 1;
    end else if (DinAck) begin
      m_valid = 0;
    end

    raw2     = btn_hist[2];
    flip_now = '0;
    for (int i = 0; i < 3; i++) begin
      if (raw2[i] != m_db[i]) begin
        m_len[i]++;
        if (m_len[i] == D) begin
          m_db[i]     = ~m_db[i];
          m_len[i]    = 0;
          flip_now[i] = m_db[i];
        end
      end else begin
        m_len[i] = 0;
      end
    end
    m_flip_up = flip_now;
    m_pulse   = rise;
    m_step    = stp;
  endtask

  task automatic checkOutput();
    checkVal("Step",       8'(Step),     8'(m_step));
    checkVal("Running",    8'(Running),  8'(m_run));
    checkVal("BtnPulse",   8'(BtnPulse), 8'(m_pulse));
    checkVal("DinLatched", DinLatched,   m_latched);
    checkVal("DinValid",   8'(DinValid), 8'(m_valid));
    checkVal("Overrun",    8'(Overrun),  8'(m_over));
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge Clock);
      modelEdge();
      #1;
      checkOutput();
      step_count   += int'(Step);
      pulse1_count += int'(BtnPulse[1]);
    end
  endtask

  initial begin
    int hold;
    Reset = 1; Btns = '0; Turbo = 1; Sample = 0; Din = '0; WaitIn = 0; DinAck = 0;
    modelReset();
    #1;
    checkOutput();
    applyStimulus(2);
    Reset = 0;

    $display("[TB] turbo run after reset");
    step_count = 0;
    applyStimulus(8);
    checkVal("turbo_steps", 8'(step_count), 8'd8);

    $display("[TB] normal-rate prescaler and turbo restart");
    Turbo = 0;
    step_count = 0;
    applyStimulus(16);
    checkVal("normal_steps", 8'(step_count), 8'd4);
    Turbo = 1;
    applyStimulus(3);
    Turbo = 0;
    step_count = 0;
    applyStimulus(3);
    checkVal("restart_gap", 8'(step_count), 8'd0);
    applyStimulus(1);
    checkVal("restart_first", 8'(Step), 8'd1);

    $display("[TB] bouncy run/halt press then single steps");
    pulse1_count = 0;
    Btns = 3'b010; applyStimulus(1);
    Btns = 3'b000; applyStimulus(1);
    Btns = 3'b010; applyStimulus(5);
    checkVal("pulse_early", 8'(BtnPulse[1]), 8'd0);
    applyStimulus(1);
    checkVal("pulse_on_time", 8'(BtnPulse[1]), 8'd1);
    checkVal("halted", 8'(Running), 8'd0);
    applyStimulus(6);
    checkVal("pulse_count", 8'(pulse1_count), 8'd1);
    Btns = 3'b000;
    step_count = 0;
    applyStimulus(8);
    checkVal("halt_no_step", 8'(step_count), 8'd0);
    repeat (2) begin
      Btns = 3'b001; applyStimulus(8);
      Btns = 3'b000; applyStimulus(8);
    end
    checkVal("single_steps", 8'(step_count), 8'd2);

    $display("[TB] pending step stalled on input");
    WaitIn = 1;
    step_count = 0;
    Btns = 3'b001; applyStimulus(8);
    Btns = 3'b000; applyStimulus(6);
    checkVal("blocked_no_step", 8'(step_count), 8'd0);
    Sample = 1; Din = 8'hA5;
    applyStimulus(3);
    checkVal("latched_a5", DinLatched, 8'hA5);
    checkVal("valid_a5", 8'(DinValid), 8'd1);
    applyStimulus(1);
    checkVal("pending_issued", 8'(Step), 8'd1);
    applyStimulus(1);
    Sample = 0; DinAck = 1;
    applyStimulus(1);
    DinAck = 0;
    checkVal("ack_clears", 8'(DinValid), 8'd0);
    applyStimulus(4);
    WaitIn = 0;

    $display("[TB] overrun and acknowledged back-to-back capture");
    Sample = 1; Din = 8'h11; applyStimulus(4);
    Sample = 0;              applyStimulus(4);
    Sample = 1; Din = 8'h22; applyStimulus(4);
    Sample = 0;              applyStimulus(4);
    checkVal("latched_22", DinLatched, 8'h22);
    checkVal("overrun_set", 8'(Overrun), 8'd1);
    applyStimulus(6);
    checkVal("overrun_sticky", 8'(Overrun), 8'd1);
    #2;
    Reset = 1;
    #1;
    modelReset();
    checkOutput();
    checkVal("async_overrun", 8'(Overrun), 8'd0);
    checkVal("async_running", 8'(Running), 8'd1);
    applyStimulus(1);
    Reset = 0;
    Sample = 1; Din = 8'h11; applyStimulus(4);
    Sample = 0;              applyStimulus(4);
    Sample = 1; Din = 8'h22; applyStimulus(2);
    DinAck = 1;              applyStimulus(1);
    DinAck = 0;
    checkVal("ack_overrun", 8'(Overrun), 8'd0);
    checkVal("ack_valid", 8'(DinValid), 8'd1);
    checkVal("ack_latched", DinLatched, 8'h22);
    applyStimulus(3);
    Sample = 0;
    applyStimulus(4);

    $display("[TB] random phase");
    hold = 0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(19) == 0) Turbo = ~Turbo;
      if ($urandom_range(7) == 0) WaitIn = ~WaitIn;
      for (int b = 0; b < 3; b++) if ($urandom_range(9) == 0) Btns[b] = ~Btns[b];
      DinAck = ($urandom_range(5) == 0);
      hold++;
      // Sample holds each level for at least 3 cycles so Din stays stable through capture
      if (hold >= 3 && $urandom_range(2) == 0) begin
        hold = 0;
        if (!Sample) Din = 8'($urandom);
        Sample = ~Sample;
      end
      applyStimulus(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
